serial_work_receiver: RTL
=========================

// Module: serial_work_receiver
// PURPOSE
//  Receive end of the host->miner getwork serial link: 8N1 UART deserialiser plus frame assembler.
//  Collects num_bytes bytes (84 = 672-bit getwork incl. 0x55aa DYNPLL header) from RxD into one word.
//  Pulses rx_done with the complete word held stable for the hashing core.
//  Partial frames are discarded on an inter-byte timeout or a framing error.
// PARAMETERS
//  comm_clk_frequency  100_000_000  clk frequency in Hz
//  baud_rate           115_200      serial bit rate
//  num_bytes           84           bytes per getwork frame; rx_data width = 8*num_bytes
//  timeout_bits        100          idle bit periods mid-frame before partial frame is discarded
// PORTS
//  clk            in   1        single clock, all logic on posedge
//  reset          in   1        synchronous, active-high
//  RxD            in   1        async serial input; idle high
//  rx_data        out  8*nb     last complete frame; updated only on frame completion
//  rx_done        out  1        1-cycle pulse, same cycle rx_data takes the new frame
//  rx_byte        out  8        last received byte (debug/LED)
//  rx_byte_valid  out  1        1-cycle pulse per good byte
//  frame_error    out  1        1-cycle pulse: bad stop bit or inter-byte timeout
//  busy           out  1        high while a frame is partially received (byte_count != 0) or a byte is in flight
// BEHAVIOUR
//  - Reset: all outputs 0; byte_count=0; FSM=IDLE; RxD synchroniser flops preset to 1.
//  - BIT_PERIOD = comm_clk_frequency/baud_rate (integer floor); HALF = BIT_PERIOD/2.
//  - RxD goes through a 2-flop synchroniser; all decisions use the synchronised value.
//  - FSM IDLE: synchronised RxD==0 -> START, bit timer cleared.
//  - FSM START: at HALF, RxD still 0 -> DATA (timer reload, bit_idx=0); else glitch -> IDLE, nothing reported.
//  - FSM DATA: sample every BIT_PERIOD at mid-bit, LSB first, shift into byte; after bit 7 -> STOP.
//  - FSM STOP: sample at mid-bit. 1 -> byte good, rx_byte/rx_byte_valid next cycle, IDLE.
//    0 -> frame_error pulse, byte discarded, byte_count=0, then IDLE (waits for RxD high before next start).
//  - Assembly: shadow shift reg; each good byte: shadow <= {byte, shadow[8*nb-1:8]}, byte_count++.
//    After num_bytes bytes the first byte received sits at rx_data[7:0] and the last at the MSBs.
//  - On byte num_bytes: rx_data <= assembled word and rx_done=1 in the same cycle; byte_count=0.
//    No partial word is ever visible on rx_data.
//  - Timeout: while byte_count!=0 and FSM==IDLE, idle counter runs; reaching timeout_bits*BIT_PERIOD
//    -> frame_error pulse, byte_count=0. Counter clears on every start bit. Inactive when byte_count==0.
//  - Simultaneous: a start edge in the same cycle as timeout expiry -> timeout wins, and the new byte begins a fresh frame.
//  - Back-to-back frames (stop bit followed directly by start bit) must be accepted with no lost byte.
//  - Reset mid-byte or mid-frame: FSM=IDLE, byte_count=0, rx_data=0; no rx_done.
//  - Latency: rx_done asserts 1 cycle after the mid-stop-bit sample of the final byte.
// STRUCTURE
//  - Shared package/header: BIT_PERIOD/HALF derivation, FSM state encodings (IDLE/START/DATA/STOP),
//    GETWORK_BYTES=84, DYNPLL header constant 16'h55aa.
//  - One sub-module: uart_rx_byte (synchroniser, bit timer, FSM; outputs byte + valid + stop_err).
//  - Top level holds byte_count, shadow register, timeout counter and the rx_data output register.
// TESTING (comm_clk_frequency=1_000_000, baud 115_200 -> BIT_PERIOD=8; drive with serial_transmit)
//  1. Send 84-byte frame 55aa07ff0000318e...01000000 -> exactly one rx_done; rx_data bytes match
//     (first byte 8'h55 at [7:0]); 84 rx_byte_valid pulses; frame_error never.
//  2. Force stop bit=0 on byte 10, then send a full frame -> one frame_error, no rx_done for the bad
//     frame; the next frame completes correctly.
//  3. Send 40 bytes, idle >100 bit periods, then 84 bytes -> one frame_error (timeout); single rx_done
//     with the 84-byte data only.
//  4. 2-cycle low glitch on idle RxD -> no rx_byte_valid, no frame_error, busy stays 0.
//  5. Assert reset after byte 50 -> rx_data=0, busy=0; a following full frame yields a correct rx_done.
//  6. Two frames back-to-back with no idle gap -> two rx_done pulses, rx_data = second frame at the end.

Source files
------------

// File: rtl/serial_work_receiver_pkg.sv
// Shared definitions for the getwork serial receiver.
//  - Bit-timing helpers: BIT_PERIOD = clk_hz / baud (floor), HALF = BIT_PERIOD / 2.
//  - Byte-level receiver FSM state encoding.
//  - Getwork frame constants: 84-byte frame and the DYNPLL header value.
package serial_work_receiver_pkg;

   localparam int          GETWORK_BYTES = 84;
   localparam logic [15:0] DYNPLL_HEADER = 16'h55aa;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   function automatic int calc_bit_period(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int calc_half_period(input int clk_hz, input int baud);
      return (clk_hz / baud) / 2;
   endfunction

endpackage

// File: rtl/serial_work_receiver_if.sv
// Output bundle of the getwork receiver plus the serial input line.
//  RxD            serial line into the receiver (idle high)
//  rx_data        last complete frame, first byte at [7:0]
//  rx_done        1-cycle pulse when rx_data takes a new frame
//  rx_byte        last good byte
//  rx_byte_valid  1-cycle pulse per good byte
//  frame_error    1-cycle pulse on bad stop bit or inter-byte timeout
//  busy           frame partially received or byte in flight
// Modports: master = receiver side, slave = host/consumer side.
// NUM_BYTES must match the receiver's num_bytes parameter.
interface serial_work_receiver_if #(
   parameter int NUM_BYTES = 84
);
   logic                   RxD;
   logic [8*NUM_BYTES-1:0] rx_data;
   logic                   rx_done;
   logic [7:0]             rx_byte;
   logic                   rx_byte_valid;
   logic                   frame_error;
   logic                   busy;

   modport master (
      input  RxD,
      output rx_data, rx_done, rx_byte, rx_byte_valid, frame_error, busy
   );

   modport slave (
      output RxD,
      input  rx_data, rx_done, rx_byte, rx_byte_valid, frame_error, busy
   );
endinterface

// File: rtl/serial_work_receiver_uart_rx_byte.sv
// uart_rx_byte: 8N1 byte deserialiser.
//  clk, reset       clock and synchronous active-high reset
//  rxd_async        raw serial input (idle high), synchronised internally
//  data_byte        assembled byte, valid while byte_strobe is high
//  byte_strobe      high for the single cycle the stop bit is sampled as 1
//  stop_err_strobe  high for the single cycle the stop bit is sampled as 0
//  start_det        start edge seen this cycle (IDLE and line low)
//  rx_idle          FSM is in IDLE
//  in_flight        a confirmed start bit is being received (DATA/STOP)
// Strobes are decoded from registered state so the parent can register
// its outputs on the very edge after the stop-bit sample.
module uart_rx_byte
   import serial_work_receiver_pkg::*;
#(
   parameter int BIT_PERIOD = 868,
   parameter int HALF       = 434
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd_async,
   output logic [7:0] data_byte,
   output logic       byte_strobe,
   output logic       stop_err_strobe,
   output logic       start_det,
   output logic       rx_idle,
   output logic       in_flight
);

   localparam int TW = $clog2(BIT_PERIOD + 1);

   logic            rxd_meta_reg;
   logic            rxd_sync_reg;
   rx_state_t       state_reg;
   logic [TW-1:0]   timer_reg;
   logic [2:0]      bit_idx_reg;
   logic [7:0]      shift_reg;
   logic            wait_high_reg;   // after a framing error, hold off until the line returns high

   logic            bit_tick;
   logic            half_tick;

   assign bit_tick  = (timer_reg == TW'(BIT_PERIOD - 1));
   assign half_tick = (timer_reg == TW'(HALF - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta_reg  <= 1'b1;
         rxd_sync_reg  <= 1'b1;
         state_reg     <= ST_IDLE;
         timer_reg     <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         wait_high_reg <= 1'b0;
      end else begin
         rxd_meta_reg <= rxd_async;
         rxd_sync_reg <= rxd_meta_reg;
         case (state_reg)
            ST_IDLE: begin
               timer_reg <= '0;
               if (wait_high_reg) begin
                  if (rxd_sync_reg)
                     wait_high_reg <= 1'b0;
               end else if (!rxd_sync_reg) begin
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (half_tick) begin
                  timer_reg <= '0;
                  // Line must still be low at mid start bit, otherwise it was a glitch
                  if (!rxd_sync_reg) begin
                     state_reg   <= ST_DATA;
                     bit_idx_reg <= '0;
                  end else begin
                     state_reg <= ST_IDLE;
                  end
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_tick) begin
                  timer_reg <= '0;
                  shift_reg <= {rxd_sync_reg, shift_reg[7:1]};   // LSB first
                  if (bit_idx_reg == 3'd7)
                     state_reg <= ST_STOP;
                  else
                     bit_idx_reg <= bit_idx_reg + 1'b1;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_tick) begin
                  timer_reg <= '0;
                  state_reg <= ST_IDLE;
                  if (!rxd_sync_reg)
                     wait_high_reg <= 1'b1;
               end else begin
                  timer_reg <= timer_reg + 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign data_byte       = shift_reg;
   assign byte_strobe     = (state_reg == ST_STOP) && bit_tick && rxd_sync_reg;
   assign stop_err_strobe = (state_reg == ST_STOP) && bit_tick && !rxd_sync_reg;
   assign start_det       = (state_reg == ST_IDLE) && !wait_high_reg && !rxd_sync_reg;
   assign rx_idle         = (state_reg == ST_IDLE);
   assign in_flight       = (state_reg == ST_DATA) || (state_reg == ST_STOP);

endmodule

// File: rtl/serial_work_receiver.sv
// serial_work_receiver: getwork frame receiver (UART + frame assembler).
//  clk    single clock
//  reset  synchronous, active-high
//  bus    serial_work_receiver_if.master: RxD in; rx_data, rx_done, rx_byte,
//         rx_byte_valid, frame_error, busy out
// Good bytes shift into a shadow register from the top, so after num_bytes
// bytes the first byte sits at [7:0]. rx_data is loaded only on frame
// completion, never with a partial word. A partial frame is dropped on a
// bad stop bit or after timeout_bits idle bit periods between bytes.
module serial_work_receiver
   import serial_work_receiver_pkg::*;
#(
   parameter int comm_clk_frequency = 100_000_000,
   parameter int baud_rate          = 115_200,
   parameter int num_bytes          = GETWORK_BYTES,
   parameter int timeout_bits       = 100
)(
   input  logic                  clk,
   input  logic                  reset,
   serial_work_receiver_if.master bus
);

   localparam int BIT_PERIOD     = calc_bit_period(comm_clk_frequency, baud_rate);
   localparam int HALF           = calc_half_period(comm_clk_frequency, baud_rate);
   localparam int TIMEOUT_CYCLES = timeout_bits * BIT_PERIOD;
   localparam int CW             = $clog2(TIMEOUT_CYCLES + 1);
   localparam int BCW            = $clog2(num_bytes + 1);

   logic [7:0]                  data_byte;
   logic                        byte_strobe;
   logic                        stop_err_strobe;
   logic                        start_det;
   logic                        rx_idle;
   logic                        in_flight;

   logic [num_bytes-1:0][7:0]   shadow_reg;
   logic [num_bytes-1:0][7:0]   shadow_next;
   logic [BCW-1:0]              byte_count_reg;
   logic [CW-1:0]               idle_cnt_reg;
   logic [8*num_bytes-1:0]      rx_data_reg;
   logic                        rx_done_reg;
   logic [7:0]                  rx_byte_reg;
   logic                        rx_byte_valid_reg;
   logic                        frame_error_reg;

   logic                        idle_active;
   logic                        timeout_hit;
   logic                        last_byte;

   uart_rx_byte #(
      .BIT_PERIOD (BIT_PERIOD),
      .HALF       (HALF)
   ) u_rx (
      .clk             (clk),
      .reset           (reset),
      .rxd_async       (bus.RxD),
      .data_byte       (data_byte),
      .byte_strobe     (byte_strobe),
      .stop_err_strobe (stop_err_strobe),
      .start_det       (start_det),
      .rx_idle         (rx_idle),
      .in_flight       (in_flight)
   );

   // Each lane takes its upper neighbour; the new byte enters the top lane.
   for (genvar gi = 0; gi < num_bytes; gi++) begin : g_lane
      if (gi == num_bytes - 1) begin : g_top
         assign shadow_next[gi] = data_byte;
      end else begin : g_mid
         assign shadow_next[gi] = shadow_reg[gi + 1];
      end
   end

   assign idle_active = (byte_count_reg != '0) && rx_idle;
   // Evaluated before the start-bit clear, so expiry coinciding with a start edge still fires
   assign timeout_hit = idle_active && (idle_cnt_reg == CW'(TIMEOUT_CYCLES - 1));
   assign last_byte   = (byte_count_reg == BCW'(num_bytes - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_reg        <= '0;
         byte_count_reg    <= '0;
         idle_cnt_reg      <= '0;
         rx_data_reg       <= '0;
         rx_done_reg       <= 1'b0;
         rx_byte_reg       <= '0;
         rx_byte_valid_reg <= 1'b0;
         frame_error_reg   <= 1'b0;
      end else begin
         rx_done_reg       <= 1'b0;
         rx_byte_valid_reg <= 1'b0;
         frame_error_reg   <= 1'b0;

         if (stop_err_strobe) begin
            frame_error_reg <= 1'b1;
            byte_count_reg  <= '0;
         end else if (byte_strobe) begin
            shadow_reg        <= shadow_next;
            rx_byte_reg       <= data_byte;
            rx_byte_valid_reg <= 1'b1;
            if (last_byte) begin
               rx_data_reg    <= shadow_next;
               rx_done_reg    <= 1'b1;
               byte_count_reg <= '0;
            end else begin
               byte_count_reg <= byte_count_reg + 1'b1;
            end
         end else if (timeout_hit) begin
            frame_error_reg <= 1'b1;
            byte_count_reg  <= '0;
         end

         if (timeout_hit || start_det || !idle_active)
            idle_cnt_reg <= '0;
         else
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
   end

   assign bus.rx_data       = rx_data_reg;
   assign bus.rx_done       = rx_done_reg;
   assign bus.rx_byte       = rx_byte_reg;
   assign bus.rx_byte_valid = rx_byte_valid_reg;
   assign bus.frame_error   = frame_error_reg;
   assign bus.busy          = (byte_count_reg != '0) || in_flight;

endmodule
